// File: rtl/regfile_write_port_if.sv
// rtl/regfile_write_port_if.sv - writeback, long-latency and register-file signals of the write port
interface regfile_write_port_if #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            ll_issue_valid;
  logic [4:0]      ll_issue_rd;
  logic            ll_resp_valid;
  logic            ll_resp_ready;
  logic [4:0]      ll_resp_rd;
  logic [XLEN-1:0] ll_resp_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_mask;
  logic            ll_bubble_req;
  logic [CW-1:0]   lq_count;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, ll_issue_valid, ll_issue_rd,
           ll_resp_valid, ll_resp_rd, ll_resp_data,
    input  ll_resp_ready, rf_we, rf_rd, rf_wdata, busy_mask, ll_bubble_req, lq_count
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, ll_issue_valid, ll_issue_rd,
           ll_resp_valid, ll_resp_rd, ll_resp_data,
    output ll_resp_ready, rf_we, rf_rd, rf_wdata, busy_mask, ll_bubble_req, lq_count
  );
endinterface

// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - register-file write arbiter with long-latency response queue and busy scoreboard
module regfile_write_port #(
  parameter int XLEN         = 32,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_write_port_if.slave bus
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      q_rd   [LQ_DEPTH];
  logic [XLEN-1:0] q_data [LQ_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve, starve_next;
  logic [31:0]     busy, busy_next;
  logic            we_q, bubble_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;

  logic pipe_sel, pop, push, ready, head_writes;

  assign pipe_sel    = bus.pipe_valid && (bus.pipe_rd != 5'd0);
  assign ready       = (count != CW'(LQ_DEPTH));
  assign push        = bus.ll_resp_valid && ready;
  // Only entries already resident are eligible, so a fresh response waits one cycle.
  assign pop         = !pipe_sel && (count != '0);
  assign head_writes = pop && (q_rd[head] != 5'd0);

  always_comb begin
    busy_next = busy;
    if (pop)
      busy_next[q_rd[head]] = 1'b0;
    if (bus.ll_issue_valid && (bus.ll_issue_rd != 5'd0))
      busy_next[bus.ll_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    starve_next = '0;
    if (pipe_sel && (count != '0))
      starve_next = (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= bus.ll_resp_rd;
      q_data[tail] <= bus.ll_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      starve   <= '0;
      bubble_q <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      busy     <= busy_next;
      starve   <= starve_next;
      bubble_q <= (starve_next >= SW'(STARVE_LIMIT));
      we_q     <= pipe_sel || head_writes;
      if (pipe_sel) begin
        rd_q   <= bus.pipe_rd;
        data_q <= bus.pipe_data;
      end else if (head_writes) begin
        rd_q   <= q_rd[head];
        data_q <= q_data[head];
      end
    end
  end

  assign bus.ll_resp_ready = ready;
  assign bus.rf_we         = we_q;
  assign bus.rf_rd         = rd_q;
  assign bus.rf_wdata      = data_q;
  assign bus.busy_mask     = busy;
  assign bus.ll_bubble_req = bubble_q;
  assign bus.lq_count      = count;
endmodule

// File: tb/tb_regfile_write_port.sv
// tb/tb_regfile_write_port.sv - randomized and directed bench against a queue-based reference model
module tb_regfile_write_port;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_port_if #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) bus ();

  regfile_write_port #(.XLEN(XLEN), .LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  ent_t        mq[$];
  logic [31:0] m_busy = '0;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wdata = '0;
  logic        m_bubble = 1'b0;

  logic [31:0] pushed[$];
  logic [31:0] seen[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic iv, input logic [4:0] ird,
                      input logic rv, input logic [4:0] rrd, input logic [31:0] rdat,
                      input logic r);
    logic exp_ready;
    logic psel;
    ent_t e;
    bus.pipe_valid     = pv;
    bus.pipe_rd        = prd;
    bus.pipe_data      = pd;
    bus.ll_issue_valid = iv;
    bus.ll_issue_rd    = ird;
    bus.ll_resp_valid  = rv;
    bus.ll_resp_rd     = rrd;
    bus.ll_resp_data   = rdat;
    rst                = r;
    exp_ready = (mq.size() != DEPTH);
    if (!r) begin
      #1;
      chk("ready", bus.ll_resp_ready, exp_ready);
    end
    if (r) begin
      mq.delete();
      m_busy = '0; m_starve = 0; m_we = 0; m_rd = '0; m_wdata = '0; m_bubble = 0;
    end else begin
      psel = pv && (prd != 0);
      if (psel && mq.size() != 0)
        m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else
        m_starve = 0;
      m_bubble = (m_starve >= LIMIT);
      if (psel) begin
        m_we = 1; m_rd = prd; m_wdata = pd;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        m_busy[e.rd] = 1'b0;
        m_we = (e.rd != 0);
        if (e.rd != 0) begin
          m_rd = e.rd; m_wdata = e.data;
        end
      end else begin
        m_we = 0;
      end
      if (iv && ird != 0)
        m_busy[ird] = 1'b1;
      m_busy[0] = 1'b0;
      if (rv && exp_ready) begin
        e.rd = rrd; e.data = rdat;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("rf_we", bus.rf_we, m_we);
    chk("rf_rd", bus.rf_rd, m_rd);
    chk("rf_wdata", bus.rf_wdata, m_wdata);
    chk("busy_mask", bus.busy_mask, m_busy);
    chk("lq_count", bus.lq_count, mq.size());
    chk("bubble", bus.ll_bubble_req, m_bubble);
    if (bus.rf_we === 1'b1)
      seen.push_back(bus.rf_wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset while pipeline and issue are active
    step(1, 5, 32'hAAAA5555, 1, 3, 0, 0, 0, 1);
    step(1, 6, 32'h11111111, 1, 4, 1, 2, 32'h5, 1);
    idle(1);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_busy", bus.busy_mask, 0);
    chk("rst_count", bus.lq_count, 0);
    chk("rst_ready", bus.ll_resp_ready, 1);

    // pipeline only
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    chk("pipe_we", bus.rf_we, 1);
    chk("pipe_rd", bus.rf_rd, 5);
    chk("pipe_data", bus.rf_wdata, 32'hDEADBEEF);
    step(1, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
    chk("pipe_rd0_we", bus.rf_we, 0);

    // long-latency path
    step(0, 0, 0, 1, 7, 0, 0, 0, 0);
    chk("ll_busy_set", bus.busy_mask[7], 1);
    step(0, 0, 0, 0, 0, 1, 7, 32'h12345678, 0);
    chk("ll_not_yet", bus.rf_we, 0);
    idle(1);
    chk("ll_we", bus.rf_we, 1);
    chk("ll_data", bus.rf_wdata, 32'h12345678);
    chk("ll_busy_clr", bus.busy_mask[7], 0);

    // full queue with continuous pipeline
    for (int i = 0; i < 4; i++)
      step(1, 3, 32'h100 + i, 0, 0, 1, 5'(10 + i), 32'hA0 + i, 0);
    chk("full_count", bus.lq_count, 4);
    chk("full_ready", bus.ll_resp_ready, 0);
    step(1, 3, 32'h200, 0, 0, 1, 14, 32'hA4, 0);
    chk("full_bubble", bus.ll_bubble_req, 1);
    step(0, 0, 0, 0, 0, 1, 14, 32'hA4, 0);
    chk("drop_count", bus.lq_count, 3);
    chk("drop_ready", bus.ll_resp_ready, 1);
    idle(6);

    // same-cycle set and clear of rd 9
    step(0, 0, 0, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 9, 32'h99, 0);
    step(0, 0, 0, 1, 9, 0, 0, 0, 0);
    chk("setclr_busy9", bus.busy_mask[9], 1);
    idle(1);

    // wrap-around ordering
    seen.delete();
    pushed.delete();
    for (int i = 0; i < 10; i++) begin
      pushed.push_back(32'h5000 + 32'(i) * 32'h11);
      step(0, 0, 0, 0, 0, 1, 5'(1 + i), 32'h5000 + 32'(i) * 32'h11, 0);
    end
    idle(3);
    chk("wrap_len", seen.size(), 10);
    for (int i = 0; i < 10 && i < seen.size(); i++)
      chk("wrap_order", seen[i], pushed[i]);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [4:0] prd;
      prd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      step(($urandom % 100) < 55, prd, $urandom,
           ($urandom % 3) == 0, 5'($urandom),
           ($urandom % 2) == 0, ($urandom % 8 == 0) ? 5'd0 : 5'($urandom), $urandom,
           ($urandom % 200) == 0);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
